coin_spawn_ctrl: RTL and testbench

//  Sequences the coin shown by coin_display: picks pseudo-random tile positions, keeps the

---
 rtl/coin_spawn_ctrl_pkg.sv | 25 ++
 rtl/coin_spawn_ctrl_lfsr16.sv | 23 ++
 rtl/coin_spawn_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_coin_spawn_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_spawn_ctrl_pkg.sv
// coin_spawn_ctrl_pkg: shared state encoding, grid defaults and tile widths for the coin controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package coin_spawn_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SPAWN    = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_COOLDOWN = 2'd3
  } coin_state_t;

  localparam int GRID_X_DEF = 20;
  localparam int GRID_Y_DEF = 15;
  localparam int TX_W       = 5;
  localparam int TY_W       = 4;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Width needed to hold 0..max_val; a zero parameter still gets one bit.
  function automatic int cnt_width(input int max_val);
    return $clog2(((max_val > 1) ? max_val : 1) + 1);
  endfunction

endpackage

// File: rtl/coin_spawn_ctrl_lfsr16.sv
// coin_lfsr16: free-running 16-bit Galois LFSR used as the coin position source.
// Latency: advances once per clk; q is the registered state.
// Backpressure: none; it never stalls.
module coin_lfsr16
  import coin_spawn_ctrl_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  // Shift right and fold the tap mask in whenever a one falls out of bit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED;
    end else begin
      q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/coin_spawn_ctrl.sv
// coin_spawn_ctrl: places the coin on a random free tile, ages it per frame, handles collection and score.
// Latency: outputs registered; spawn takes 1..MAX_TRIES cycles, collect/expire appear one cycle after sampling.
// Backpressure: none; enable/frame_tick/reach_coin are sampled every cycle and never stalled.
module coin_spawn_ctrl
  import coin_spawn_ctrl_pkg::*;
#(
  parameter int          GRID_X          = GRID_X_DEF,
  parameter int          GRID_Y          = GRID_Y_DEF,
  parameter int          LIFETIME_FRAMES = 300,
  parameter int          RESPAWN_FRAMES  = 30,
  parameter int          MAX_TRIES       = 8,
  parameter logic [15:0] SEED            = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            frame_tick,
  input  logic            reach_coin,
  input  logic            clear_score,
  input  logic [TX_W-1:0] player_tx,
  input  logic [TY_W-1:0] player_ty,
  output logic [TX_W-1:0] coin_tx,
  output logic [TY_W-1:0] coin_ty,
  output logic            coin_on,
  output logic            collect_pulse,
  output logic            expire_pulse,
  output logic [7:0]      score
);

  localparam int LIFE_W = cnt_width(LIFETIME_FRAMES);
  localparam int COOL_W = cnt_width(RESPAWN_FRAMES);
  localparam int TRY_W  = cnt_width(MAX_TRIES);

  localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(LIFETIME_FRAMES);
  localparam logic [COOL_W-1:0] COOL_INIT = COOL_W'(RESPAWN_FRAMES);
  localparam logic [TRY_W-1:0]  TRY_LAST  = TRY_W'((MAX_TRIES > 0) ? MAX_TRIES - 1 : 0);
  localparam logic [5:0]        GRID_X_L  = 6'(GRID_X);
  localparam logic [4:0]        GRID_Y_L  = 5'(GRID_Y);
  localparam logic [5:0]        HALF_X    = 6'(GRID_X / 2);
  localparam bit                LIFE_EN   = (LIFETIME_FRAMES != 0);

  coin_state_t       state, state_n;
  logic [15:0]       lfsr_q;
  logic [6:0]        lfsr_unused;
  logic [TX_W-1:0]   cand_x, fb_x;
  logic [TY_W-1:0]   cand_y;
  logic              cand_ok;
  logic [5:0]        fb_sum;
  logic [LIFE_W-1:0] life, life_n;
  logic [COOL_W-1:0] cool, cool_n;
  logic [TRY_W-1:0]  tries, tries_n;
  logic [TX_W-1:0]   coin_tx_n;
  logic [TY_W-1:0]   coin_ty_n;
  logic              coin_on_n, collect_n, expire_n;
  logic [7:0]        score_n;

  coin_lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // Only the low nine LFSR bits feed the candidate tile.
  assign lfsr_unused = lfsr_q[15:9];
  assign cand_x      = lfsr_q[4:0];
  assign cand_y      = lfsr_q[8:5];

  assign cand_ok = ({1'b0, cand_x} < GRID_X_L) &&
                   ({1'b0, cand_y} < GRID_Y_L) &&
                   !((cand_x == player_tx) && (cand_y == player_ty));

  // Fallback sits half a screen across from the player on the same row.
  assign fb_sum = {1'b0, player_tx} + HALF_X;
  assign fb_x   = TX_W'(fb_sum % GRID_X_L);

  // Next-state and next-output decode; enable low overrides every state.
  always_comb begin
    state_n   = state;
    coin_tx_n = coin_tx;
    coin_ty_n = coin_ty;
    coin_on_n = coin_on;
    collect_n = 1'b0;
    expire_n  = 1'b0;
    life_n    = life;
    cool_n    = cool;
    tries_n   = tries;
    if (!enable) begin
      state_n   = ST_IDLE;
      coin_on_n = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_n = ST_SPAWN;
          tries_n = '0;
        end
        ST_SPAWN: begin
          if (cand_ok) begin
            coin_tx_n = cand_x;
            coin_ty_n = cand_y;
            coin_on_n = 1'b1;
            life_n    = LIFE_INIT;
            state_n   = ST_ACTIVE;
          end else begin
            tries_n = tries + TRY_W'(1);
            if (tries == TRY_LAST) begin
              coin_tx_n = fb_x;
              coin_ty_n = player_ty;
              coin_on_n = 1'b1;
              life_n    = LIFE_INIT;
              state_n   = ST_ACTIVE;
            end
          end
        end
        ST_ACTIVE: begin
          // Collection is checked first so it wins over a coincident final tick.
          if (reach_coin) begin
            coin_on_n = 1'b0;
            collect_n = 1'b1;
            cool_n    = COOL_INIT;
            state_n   = ST_COOLDOWN;
          end else if (frame_tick && LIFE_EN && (life != '0)) begin
            life_n = life - LIFE_W'(1);
            if (life == LIFE_W'(1)) begin
              coin_on_n = 1'b0;
              expire_n  = 1'b1;
              cool_n    = COOL_INIT;
              state_n   = ST_COOLDOWN;
            end
          end
        end
        ST_COOLDOWN: begin
          if (cool == '0) begin
            state_n = ST_SPAWN;
            tries_n = '0;
          end else if (frame_tick) begin
            cool_n = cool - COOL_W'(1);
            if (cool == COOL_W'(1)) begin
              state_n = ST_SPAWN;
              tries_n = '0;
            end
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // Score: clear beats increment; increment saturates at 255.
  always_comb begin
    score_n = score;
    if (clear_score) begin
      score_n = 8'd0;
    end else if (collect_n && (score != 8'hFF)) begin
      score_n = score + 8'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Registered coin position, counters, pulses and score.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coin_tx       <= '0;
      coin_ty       <= '0;
      coin_on       <= 1'b0;
      collect_pulse <= 1'b0;
      expire_pulse  <= 1'b0;
      score         <= 8'd0;
      life          <= '0;
      cool          <= '0;
      tries         <= '0;
    end else begin
      coin_tx       <= coin_tx_n;
      coin_ty       <= coin_ty_n;
      coin_on       <= coin_on_n;
      collect_pulse <= collect_n;
      expire_pulse  <= expire_n;
      score         <= score_n;
      life          <= life_n;
      cool          <= cool_n;
      tries         <= tries_n;
    end
  end

endmodule

// File: tb/tb_coin_spawn_ctrl.sv
// tb_coin_spawn_ctrl: random and directed stimulus for coin_spawn_ctrl against an event-level model.
// Latency: model predicts each coin event for the edge on which the DUT registers it.
// Backpressure: none; the monitor consumes one predicted event per observed DUT event.
`timescale 1ns/1ps
module tb_coin_spawn_ctrl;

  localparam int GX   = 20;
  localparam int GY   = 15;
  localparam int LIFE = 4;
  localparam int RESP = 5;
  localparam int MT   = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  localparam int EV_SPAWN   = 0;
  localparam int EV_COLLECT = 1;
  localparam int EV_EXPIRE  = 2;
  localparam int EV_DROP    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, enable, frame_tick, reach_coin, clear_score;
  logic [4:0] player_tx, coin_tx;
  logic [3:0] player_ty, coin_ty;
  logic       coin_on, collect_pulse, expire_pulse;
  logic [7:0] score;

  logic       en2, tick2, reach2, clr2;
  logic [4:0] p2x, c2x;
  logic [3:0] p2y, c2y;
  logic       on2, col2, exp2;
  logic [7:0] score2;

  coin_spawn_ctrl #(
    .GRID_X(GX), .GRID_Y(GY), .LIFETIME_FRAMES(LIFE), .RESPAWN_FRAMES(RESP),
    .MAX_TRIES(MT), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick),
    .reach_coin(reach_coin), .clear_score(clear_score),
    .player_tx(player_tx), .player_ty(player_ty),
    .coin_tx(coin_tx), .coin_ty(coin_ty), .coin_on(coin_on),
    .collect_pulse(collect_pulse), .expire_pulse(expire_pulse), .score(score)
  );

  // Single-tile grid with the player on it: every draw is rejected.
  coin_spawn_ctrl #(
    .GRID_X(1), .GRID_Y(1), .LIFETIME_FRAMES(0), .RESPAWN_FRAMES(0),
    .MAX_TRIES(MT), .SEED(16'h1234)
  ) dut2 (
    .clk(clk), .rst(rst), .enable(en2), .frame_tick(tick2),
    .reach_coin(reach2), .clear_score(clr2),
    .player_tx(p2x), .player_ty(p2y),
    .coin_tx(c2x), .coin_ty(c2y), .coin_on(on2),
    .collect_pulse(col2), .expire_pulse(exp2), .score(score2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int kind; int x; int y; } ev_t;
  ev_t evq[$];

  bit          m_run, m_seek, m_on;
  int          m_life, m_cool, m_tries, m_score, m_x, m_y;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_reset();
    m_run = 0; m_seek = 0; m_on = 0;
    m_life = 0; m_cool = 0; m_tries = 0; m_score = 0; m_x = 0; m_y = 0;
    m_lfsr = SEED;
    evq.delete();
  endtask

  task automatic push_ev(input int k, input int x, input int y);
    ev_t e;
    e.kind = k; e.x = x; e.y = y;
    evq.push_back(e);
  endtask

  task automatic place(input int x, input int y);
    m_on = 1; m_seek = 0; m_x = x; m_y = y; m_life = LIFE;
    push_ev(EV_SPAWN, x, y);
  endtask

  task automatic retire(input int k);
    m_on = 0; m_cool = RESP;
    push_ev(k, m_x, m_y);
  endtask

  task automatic model_step();
    int x, y;
    bit got;
    got = 0;
    x = int'(m_lfsr[4:0]);
    y = int'(m_lfsr[8:5]);
    if (!enable) begin
      if (m_on) push_ev(EV_DROP, m_x, m_y);
      m_on = 0; m_run = 0; m_seek = 0;
    end else if (!m_run) begin
      m_run = 1; m_seek = 1; m_tries = 0;
    end else if (m_seek) begin
      if (x < GX && y < GY && !(x == int'(player_tx) && y == int'(player_ty))) place(x, y);
      else begin
        m_tries++;
        if (m_tries >= MT) place((int'(player_tx) + GX / 2) % GX, int'(player_ty));
      end
    end else if (m_on) begin
      if (reach_coin) begin
        retire(EV_COLLECT);
        got = 1;
      end else if (frame_tick && LIFE != 0) begin
        m_life--;
        if (m_life == 0) retire(EV_EXPIRE);
      end
    end else begin
      if (m_cool == 0) begin
        m_seek = 1; m_tries = 0;
      end else if (frame_tick) begin
        m_cool--;
        if (m_cool == 0) begin m_seek = 1; m_tries = 0; end
      end
    end
    if (clear_score) m_score = 0;
    else if (got && m_score < 255) m_score++;
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  always @(posedge clk) if (rst) model_step();

  // ---------------- monitor ----------------
  bit prev_on = 0;

  task automatic monitor_step();
    int  kind;
    ev_t e;
    kind = -1;
    if (!rst) begin
      prev_on = 0;
      chk("reset_outputs", int'({coin_tx, coin_ty, coin_on, collect_pulse, expire_pulse, score}), 0);
      return;
    end
    if (collect_pulse) kind = EV_COLLECT;
    else if (expire_pulse) kind = EV_EXPIRE;
    else if (coin_on && !prev_on) kind = EV_SPAWN;
    else if (!coin_on && prev_on) kind = EV_DROP;
    if (kind >= 0) begin
      if (evq.size() == 0) chk("unexpected_event", kind, -1);
      else begin
        e = evq.pop_front();
        chk("event_kind", kind, e.kind);
        if (kind == EV_SPAWN) begin
          chk("spawn_x", int'(coin_tx), e.x);
          chk("spawn_y", int'(coin_ty), e.y);
          chk("spawn_in_grid", int'(coin_tx < GX && coin_ty < GY), 1);
        end else begin
          chk("coin_off_after_event", int'(coin_on), 0);
        end
      end
    end else if (evq.size() != 0) begin
      e = evq.pop_front();
      chk("missing_event", -1, e.kind);
    end
    if (coin_on && prev_on) begin
      chk("tile_hold_x", int'(coin_tx), m_x);
      chk("tile_hold_y", int'(coin_ty), m_y);
    end
    chk("score", int'(score), m_score);
    prev_on = coin_on;
  endtask

  always @(negedge clk) monitor_step();

  // ---------------- stimulus helpers ----------------
  task automatic wait_coin(input string name, input int budget);
    int n;
    bit seen;
    n = 0; seen = 0; reach_coin = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (coin_on) seen = 1;
      else frame_tick = 1;
    end
    frame_tick = 0;
    chk(name, int'(seen), 1);
  endtask

  task automatic wait_coin2(input string name);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = on2;
    end
    chk(name, n, MT + 1);
  endtask

  task automatic random_phase(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      enable      = ($urandom_range(0, 99) != 0);
      frame_tick  = ($urandom_range(0, 2) == 0);
      reach_coin  = ($urandom_range(0, 7) == 0);
      clear_score = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) begin
        player_tx = 5'($urandom_range(0, GX - 1));
        player_ty = 4'($urandom_range(0, GY - 1));
      end
    end
  endtask

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    int n;
    bit seen;
    rst = 0; enable = 0; frame_tick = 0; reach_coin = 0; clear_score = 0;
    player_tx = 0; player_ty = 0;
    en2 = 0; tick2 = 0; reach2 = 0; clr2 = 0; p2x = 0; p2y = 0;
    model_reset();
    repeat (3) @(negedge clk);
    enable = 1;
    #2 rst = 1;

    // First spawn after reset with the player at (0,0).
    n = 0; seen = 0;
    while (!seen && n < MT + 3) begin
      @(negedge clk);
      n++;
      seen = coin_on;
    end
    chk("t1_spawn_within_limit", int'(seen && n <= MT + 1), 1);

    // All draws rejected: fallback tile after MAX_TRIES rejects, no expiry, instant respawn.
    en2 = 1;
    wait_coin2("t6_fallback_cycles");
    chk("t6_fallback_x", int'(c2x), 0);
    chk("t6_fallback_y", int'(c2y), 0);
    tick2 = 1;
    repeat (10) @(negedge clk);
    tick2 = 0;
    chk("t6_never_expires", int'(on2), 1);
    reach2 = 1;
    @(negedge clk);
    reach2 = 0;
    chk("t6_collect", int'(col2), 1);
    chk("t6_score", int'(score2), 1);
    wait_coin2("t6_zero_respawn_cycles");
    en2 = 0;
    @(negedge clk);
    chk("t6_disable_coin_off", int'(on2), 0);
    chk("t6_disable_no_pulse", int'(col2 | exp2), 0);
    chk("t6_disable_score_held", int'(score2), 1);

    // One-cycle collect, then respawn after RESP frame ticks.
    wait_coin("t2_coin_up", 4);
    reach_coin = 1;
    @(negedge clk);
    reach_coin = 0;
    chk("t2_collect_pulse", int'(collect_pulse), 1);
    chk("t2_coin_off", int'(coin_on), 0);
    chk("t2_score_one", int'(score), 1);
    wait_coin("t2_respawn", RESP + MT + 4);

    // Expiry on the LIFE-th tick with no reach.
    frame_tick = 1;
    for (int i = 0; i < LIFE; i++) begin
      @(negedge clk);
      if (i < LIFE - 1) chk("t3_alive_before_last_tick", int'(coin_on), 1);
    end
    frame_tick = 0;
    chk("t3_expire_pulse", int'(expire_pulse), 1);
    chk("t3_score_unchanged", int'(score), 1);

    // Reach coincides with the final life tick: collect wins.
    wait_coin("t4_coin_up", RESP + MT + 4);
    frame_tick = 1;
    repeat (LIFE - 1) @(negedge clk);
    reach_coin = 1;
    @(negedge clk);
    reach_coin = 0; frame_tick = 0;
    chk("t4_collect_pulse", int'(collect_pulse), 1);
    chk("t4_no_expire", int'(expire_pulse), 0);
    chk("t4_score_two", int'(score), 2);

    // Reach held for 50 cycles counts once.
    wait_coin("t5_coin_up", RESP + MT + 4);
    reach_coin = 1;
    repeat (50) @(negedge clk);
    reach_coin = 0;
    chk("t5_held_reach_once", int'(score), 3);

    // Asynchronous reset while cooling down.
    @(negedge clk);
    #2 rst = 0;
    model_reset();
    #1;
    chk("t6_async_reset_main", int'({coin_tx, coin_ty, coin_on, collect_pulse, expire_pulse, score}), 0);
    chk("t6_async_reset_dut2", int'({c2x, c2y, on2, col2, exp2, score2}), 0);
    repeat (3) @(negedge clk);
    #2 rst = 1;

    random_phase(3000);

    // Saturate the score.
    @(negedge clk);
    enable = 1; clear_score = 0; frame_tick = 1; reach_coin = 1;
    repeat (4500) @(negedge clk);
    chk("t5_score_saturated", int'(score), 255);
    repeat (100) @(negedge clk);
    chk("t5_score_stays_255", int'(score), 255);
    wait_coin("t5_coin_up_sat", RESP + MT + 4);
    reach_coin = 1; clear_score = 1;
    @(negedge clk);
    reach_coin = 0; clear_score = 0;
    chk("t5_clear_with_collect_pulse", int'(collect_pulse), 1);
    chk("t5_clear_beats_increment", int'(score), 0);

    random_phase(1000);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
